// File: rtl/maxpool_if.sv
// Handshake bundle between the command sequencer / data streams and maxpool_engine.
// The engine uses the slave modport; the sequencer or bench uses master.
interface maxpool_if;
  logic        engine_reset;
  logic        maxpool_ready;
  logic [7:0]  kernel_size;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        data_in_rdy;
  logic [15:0] result;
  logic        result_valid;
  logic        result_rdy;
  logic        maxpool_valid;

  modport master (
    output engine_reset, maxpool_ready, kernel_size, data_in, data_in_valid, result_rdy,
    input  data_in_rdy, result, result_valid, maxpool_valid
  );

  modport slave (
    input  engine_reset, maxpool_ready, kernel_size, data_in, data_in_valid, result_rdy,
    output data_in_rdy, result, result_valid, maxpool_valid
  );
endinterface

// File: rtl/maxpool_engine.sv
// FP16 K x K max-pool engine: streams K*K samples per window and emits the window maximum.
// Optional fused ReLU on the result when MAXPOOL_RELU_EN is defined.
module maxpool_engine (
  input logic      clk,
  input logic      rst,
  maxpool_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  logic [1:0]  state;
  logic [3:0]  k_lat;
  logic [3:0]  k_clamped;
  logic [7:0]  sample_cnt;
  logic [7:0]  win_len;
  logic [3:0]  group_cnt;
  logic [15:0] run_max;
  logic [15:0] next_max;
  logic [15:0] out_val;
  logic [15:0] result_q;
  logic        result_valid_q;
  logic        maxpool_valid_q;
  logic        accept;
  logic        last_sample;

  // Maps FP16 onto an unsigned key whose order matches numeric order (+0 above -0).
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  always_comb begin
    k_clamped = bus.kernel_size[3:0];
    if (bus.kernel_size == 8'd0)
      k_clamped = 4'd1;
    else if (bus.kernel_size > 8'd15)
      k_clamped = 4'd15;
  end

  assign win_len     = {4'd0, k_lat} * {4'd0, k_lat};
  assign accept      = (state == ACCUM) && bus.data_in_valid;
  assign last_sample = accept && (sample_cnt == win_len - 8'd1);

  always_comb begin
    next_max = run_max;
    if (sample_cnt == 8'd0 || fp16_key(bus.data_in) > fp16_key(run_max))
      next_max = bus.data_in;
`ifdef MAXPOOL_RELU_EN
    out_val = next_max[15] ? 16'h0000 : next_max;
`else
    out_val = next_max;
`endif
  end

  assign bus.data_in_rdy   = (state == ACCUM);
  assign bus.result        = result_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.maxpool_valid = maxpool_valid_q;

  // engine_reset behaves exactly like rst so an aborted command leaves no residue.
  always_ff @(posedge clk) begin
    if (rst || bus.engine_reset) begin
      state           <= IDLE;
      k_lat           <= 4'd1;
      sample_cnt      <= 8'd0;
      group_cnt       <= 4'd0;
      run_max         <= 16'h0000;
      result_q        <= 16'h0000;
      result_valid_q  <= 1'b0;
      maxpool_valid_q <= 1'b0;
    end else begin
      maxpool_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.maxpool_ready) begin
            state <= ACCUM;
            k_lat <= k_clamped;
          end
        end
        ACCUM: begin
          if (accept) begin
            run_max    <= next_max;
            sample_cnt <= sample_cnt + 8'd1;
            if (last_sample) begin
              state          <= OUT;
              result_q       <= out_val;
              result_valid_q <= 1'b1;
            end
          end
        end
        OUT: begin
          if (bus.result_rdy) begin
            result_valid_q <= 1'b0;
            group_cnt      <= group_cnt + 4'd1;
            sample_cnt     <= 8'd0;
            run_max        <= 16'h0000;
            if (group_cnt == 4'd15)
              maxpool_valid_q <= 1'b1;
            state <= bus.maxpool_ready ? ACCUM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
